// File: rtl/updown_counter_mc.sv
// updown_counter_mc: parametrised up/down counter with programmable limit,
// wrap / saturate / one-shot modes, terminal-count and wrap pulses.
//
// Ports:
//   clock      rising-edge clock
//   clear_n    asynchronous active-low reset
//   enable     count enable
//   load       synchronous load of load_data (highest priority)
//   load_data  value to load, stored as-is even above limit
//   updown     1 = count up, 0 = count down
//   step       amount added/subtracted per counting cycle
//   limit      upper bound of the counting range 0..limit
//   mode       0 wrap, 1 saturate, 2 one-shot, 3 treated as wrap
//   start      one-shot arm/restart
//   counter    registered count
//   tc         one-cycle pulse when a count lands on the terminal value
//   wrap       one-cycle pulse when a modular wrap occurred
//   running    one-shot sequencer is counting
//   done       one-shot sequencer has reached terminal
module updown_counter_mc #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STEP_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  updown,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit,
    input  logic [1:0]            mode,
    input  logic                  start,
    output logic [WIDTH-1:0]      counter,
    output logic                  tc,
    output logic                  wrap,
    output logic                  running,
    output logic                  done
);

    localparam int unsigned EW = WIDTH + 1;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            running_next;
    logic            done_next;

    logic [1:0]      mode_eff;
    logic            oneshot;
    logic            start_hit;
    logic            count_en;
    logic            wrap_ok;

    logic [EW-1:0]   cnt_ext;
    logic [EW-1:0]   step_ext;
    logic [EW-1:0]   lim_ext;
    logic [EW-1:0]   lim_p1;
    logic [EW-1:0]   up_sum;
    logic [EW-1:0]   terminal;
    logic [EW-1:0]   res;

    logic [WIDTH-1:0] counter_next;
    logic             tc_next;
    logic             wrap_next;

    // Reserved mode 3 behaves exactly like wrap mode.
    assign mode_eff  = (mode == 2'd3) ? MODE_WRAP : mode;
    assign oneshot   = (mode_eff == MODE_ONESHOT);
    assign start_hit = oneshot && start && !load;
    assign count_en  = !load && !start_hit && enable && (step != '0)
                       && (!oneshot || (state == S_RUN));

    // One bit of headroom so sums and differences never truncate.
    assign cnt_ext  = EW'(counter);
    assign step_ext = EW'(step);
    assign lim_ext  = EW'(limit);
    assign lim_p1   = lim_ext + EW'(1);
    assign up_sum   = cnt_ext + step_ext;
    assign terminal = updown ? lim_ext : '0;

    // A step larger than the range cannot wrap meaningfully; it saturates.
    assign wrap_ok  = (mode_eff == MODE_WRAP) && (step_ext <= lim_p1);

    // Next count value and flag pulses.
    always_comb begin
        counter_next = counter;
        tc_next      = 1'b0;
        wrap_next    = 1'b0;
        res          = cnt_ext;
        if (load) begin
            counter_next = load_data;
        end else if (start_hit) begin
            counter_next = updown ? '0 : limit;
        end else if (count_en) begin
            if (cnt_ext > lim_ext) begin
                // Out-of-range value is pulled back to limit, never wrapped.
                res = lim_ext;
            end else if (updown) begin
                if (up_sum <= lim_ext) begin
                    res = up_sum;
                end else if (wrap_ok) begin
                    res       = up_sum - lim_p1;
                    wrap_next = 1'b1;
                end else begin
                    res = lim_ext;
                end
            end else begin
                if (cnt_ext >= step_ext) begin
                    res = cnt_ext - step_ext;
                end else if (wrap_ok) begin
                    res       = cnt_ext + lim_p1 - step_ext;
                    wrap_next = 1'b1;
                end else begin
                    res = '0;
                end
            end
            counter_next = res[WIDTH-1:0];
            // Holding at terminal does not re-pulse, except when the range is
            // a single value (limit 0) or a wrap landed on it.
            tc_next = (res == terminal)
                      && ((res != cnt_ext) || wrap_next || (limit == '0));
        end
    end

    // Datapath register: count and flags update together.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            counter <= '0;
            tc      <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            counter <= counter_next;
            tc      <= tc_next;
            wrap    <= wrap_next;
        end
    end

    // One-shot state register with registered status outputs.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= S_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            running <= running_next;
            done    <= done_next;
        end
    end

    // One-shot next state; leaving mode 2 always returns to IDLE.
    always_comb begin
        state_next = state;
        if (!oneshot) begin
            state_next = S_IDLE;
        end else if (load) begin
            state_next = state;
        end else if (start_hit) begin
            state_next = S_RUN;
        end else if ((state == S_RUN) && count_en && tc_next) begin
            state_next = S_DONE;
        end
    end

    // One-shot status decode of the upcoming state.
    always_comb begin
        running_next = 1'b0;
        done_next    = 1'b0;
        if (state_next == S_RUN) begin
            running_next = 1'b1;
        end
        if (state_next == S_DONE) begin
            done_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_updown_counter_mc.sv
// tb_updown_counter_mc: directed and short random stimulus for
// updown_counter_mc (WIDTH=4) against an integer reference model, plus
// hand-computed literal expectations.
`timescale 1ns/1ps
module tb_updown_counter_mc;

    localparam int unsigned W  = 4;
    localparam int unsigned SW = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic          clock = 1'b0;
    logic          clear_n;
    logic          enable;
    logic          load;
    logic [W-1:0]  load_data;
    logic          updown;
    logic [SW-1:0] step;
    logic [W-1:0]  limit;
    logic [1:0]    mode;
    logic          start;
    logic [W-1:0]  counter;
    logic          tc;
    logic          wrap;
    logic          running;
    logic          done;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    always #5 clock = ~clock;

    updown_counter_mc #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .enable    (enable),
        .load      (load),
        .load_data (load_data),
        .updown    (updown),
        .step      (step),
        .limit     (limit),
        .mode      (mode),
        .start     (start),
        .counter   (counter),
        .tc        (tc),
        .wrap      (wrap),
        .running   (running),
        .done      (done)
    );

    typedef struct packed {
        int cnt;
        bit tc;
        bit wr;
        int st;
    } mstate_t;

    mstate_t m;

    // Reference behaviour in plain integer arithmetic.
    function automatic mstate_t model_next(input mstate_t cur, input bit ld,
                                           input int ldd, input bit en,
                                           input bit up, input int s,
                                           input int lim, input int md,
                                           input bit strt);
        mstate_t r;
        int      mm;
        int      c;
        int      term;
        mm   = (md == 3) ? 0 : md;
        c    = cur.cnt;
        r    = cur;
        r.tc = 1'b0;
        r.wr = 1'b0;
        if (mm != 2) r.st = M_IDLE;
        if (ld) begin
            r.cnt = ldd;
            return r;
        end
        if (mm == 2 && strt) begin
            r.st  = M_RUN;
            r.cnt = up ? 0 : lim;
            return r;
        end
        if (!en || (mm == 2 && cur.st != M_RUN) || s == 0) return r;
        term = up ? lim : 0;
        if (c > lim) begin
            r.cnt = lim;
        end else if (up) begin
            if (c + s <= lim)                 r.cnt = c + s;
            else if (mm == 0 && s <= lim + 1) begin r.cnt = c + s - (lim + 1); r.wr = 1'b1; end
            else                              r.cnt = lim;
        end else begin
            if (c >= s)                       r.cnt = c - s;
            else if (mm == 0 && s <= lim + 1) begin r.cnt = c + (lim + 1) - s; r.wr = 1'b1; end
            else                              r.cnt = 0;
        end
        r.tc = (r.cnt == term) && (r.cnt != c || r.wr || lim == 0);
        if (mm == 2 && r.tc) r.st = M_DONE;
        return r;
    endfunction

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m <= '{cnt: 0, tc: 1'b0, wr: 1'b0, st: M_IDLE};
        end else begin
            m <= model_next(m, load, int'(load_data), enable, updown, int'(step),
                            int'(limit), int'(mode), start);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("model counter", 32'(counter), 32'(m.cnt));
            chk("model tc",      32'(tc),      32'(m.tc));
            chk("model wrap",    32'(wrap),    32'(m.wr));
            chk("model running", 32'(running), 32'(m.st == M_RUN));
            chk("model done",    32'(done),    32'(m.st == M_DONE));
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        clear_n   = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        load_data = '0;
        updown    = 1'b1;
        step      = 4'd1;
        limit     = 4'd15;
        mode      = 2'd0;
        start     = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset counter", 32'(counter), 32'd0);
        chk("reset tc",      32'(tc),      32'd0);
        chk("reset wrap",    32'(wrap),    32'd0);
        chk("reset running", 32'(running), 32'd0);
        chk("reset done",    32'(done),    32'd0);
        cmp_on  = 1'b1;
        clear_n = 1'b1;

        // Load then asynchronous reset between edges.
        load = 1'b1; load_data = 4'd9;
        cyc();
        chk("load counter", 32'(counter), 32'd9);
        chk("load tc",      32'(tc),      32'd0);
        load = 1'b0;
        #2 clear_n = 1'b0;
        #1 chk("async reset counter", 32'(counter), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;

        // Wrap mode, limit 9, step 3.
        limit = 4'd9; step = 4'd3; mode = 2'd0; updown = 1'b1;
        load = 1'b1; load_data = 4'd0;
        cyc();
        load = 1'b0; enable = 1'b1;
        cyc(); cyc(); cyc();
        chk("wrap up at 9 counter", 32'(counter), 32'd9);
        chk("wrap up at 9 tc",      32'(tc),      32'd1);
        cyc();
        chk("wrap up to 2 counter", 32'(counter), 32'd2);
        chk("wrap up to 2 wrap",    32'(wrap),    32'd1);
        chk("wrap up to 2 tc",      32'(tc),      32'd0);
        updown = 1'b0;
        cyc();
        chk("wrap down counter", 32'(counter), 32'd9);
        chk("wrap down wrap",    32'(wrap),    32'd1);
        chk("wrap down tc",      32'(tc),      32'd0);

        // Saturate, limit 12, step 5; load wins over enable.
        mode = 2'd1; limit = 4'd12; step = 4'd5; updown = 1'b1;
        load = 1'b1; load_data = 4'd10;
        cyc();
        chk("load beats enable", 32'(counter), 32'd10);
        load = 1'b0;
        cyc();
        chk("sat up counter", 32'(counter), 32'd12);
        chk("sat up tc",      32'(tc),      32'd1);
        cyc();
        chk("sat hold counter", 32'(counter), 32'd12);
        chk("sat hold tc",      32'(tc),      32'd0);
        load = 1'b1; load_data = 4'd3; updown = 1'b0;
        cyc();
        load = 1'b0;
        cyc();
        chk("sat down counter", 32'(counter), 32'd0);
        chk("sat down tc",      32'(tc),      32'd1);

        // One-shot, limit 5, step 1.
        enable = 1'b0; mode = 2'd2; limit = 4'd5; step = 4'd1; updown = 1'b1;
        start = 1'b1;
        cyc();
        chk("os start counter", 32'(counter), 32'd0);
        chk("os start running", 32'(running), 32'd1);
        start = 1'b0; enable = 1'b1;
        repeat (4) cyc();
        chk("os mid counter", 32'(counter), 32'd4);
        cyc();
        chk("os end counter", 32'(counter), 32'd5);
        chk("os end tc",      32'(tc),      32'd1);
        chk("os end done",    32'(done),    32'd1);
        chk("os end running", 32'(running), 32'd0);
        cyc();
        chk("os hold counter", 32'(counter), 32'd5);
        chk("os hold tc",      32'(tc),      32'd0);
        start = 1'b1;
        cyc();
        chk("os restart counter", 32'(counter), 32'd0);
        chk("os restart running", 32'(running), 32'd1);
        start = 1'b0;

        // Out-of-range load, then step 0.
        mode = 2'd0; limit = 4'd9; updown = 1'b1; step = 4'd1;
        load = 1'b1; load_data = 4'd14;
        cyc();
        chk("oor load counter", 32'(counter), 32'd14);
        load = 1'b0;
        cyc();
        chk("oor count counter", 32'(counter), 32'd9);
        chk("oor count wrap",    32'(wrap),    32'd0);
        step = 4'd0;
        cyc();
        chk("step0 counter", 32'(counter), 32'd9);
        chk("step0 tc",      32'(tc),      32'd0);
        chk("step0 wrap",    32'(wrap),    32'd0);

        // Mode change out of one-shot RUN.
        step = 4'd1; mode = 2'd2; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        chk("mc run counter", 32'(counter), 32'd3);
        mode = 2'd0;
        cyc();
        chk("mc idle running", 32'(running), 32'd0);
        chk("mc wrap counter", 32'(counter), 32'd4);

        // limit 0.
        limit = 4'd0; load = 1'b1; load_data = 4'd0;
        cyc();
        load = 1'b0;
        cyc();
        chk("lim0 up tc",   32'(tc),   32'd1);
        chk("lim0 up wrap", 32'(wrap), 32'd1);
        updown = 1'b0;
        cyc();
        chk("lim0 down tc",   32'(tc),   32'd1);
        chk("lim0 down wrap", 32'(wrap), 32'd1);
        mode = 2'd1;
        cyc();
        chk("lim0 sat tc",   32'(tc),   32'd1);
        chk("lim0 sat wrap", 32'(wrap), 32'd0);

        // Reserved mode acts as wrap.
        mode = 2'd3; limit = 4'd9; step = 4'd3; updown = 1'b1;
        load = 1'b1; load_data = 4'd8;
        cyc();
        load = 1'b0;
        cyc();
        chk("mode3 counter", 32'(counter), 32'd1);
        chk("mode3 wrap",    32'(wrap),    32'd1);

        // Short random soak checked by the model.
        for (int i = 0; i < 300; i++) begin
            load      = ($urandom_range(0, 9) == 0);
            load_data = W'($urandom_range(0, 15));
            enable    = ($urandom_range(0, 3) != 0);
            updown    = 1'($urandom_range(0, 1));
            step      = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) limit = W'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            start     = ($urandom_range(0, 11) == 0);
            cyc();
        end

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
